alu_issue_queue: RTL

- Upstream operand-issue stage for the registered ALU datapath.
- Buffers (opcode, dataa, datab) triples from a ready/valid producer in a small circular FIFO.
- Issues at most one triple per cycle onto registered ALU operand outputs, gated by a stall/enable.
- Generates result_valid, aligned to the ALU's result latency, so the consumer knows which ALU result cycles are real.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_valid_pipe.sv | 31 +++
 rtl/alu_issue_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand/opcode widths and the opcode encoding.
// Used by the ALU, its issue queue and the bench.
package alu_pkg;

  localparam int ALU_DATAW   = 16;
  localparam int ALU_OPS     = 4;
  localparam int ALU_OPCODEW = $clog2(ALU_OPS);

  typedef enum logic [ALU_OPCODEW-1:0] {
    OP_ADD     = 2'd0,
    OP_A_SUB_B = 2'd1,
    OP_B_SUB_A = 2'd2,
    OP_MUL     = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_valid_pipe.sv
// RES_LAT-deep 1-bit shift register tracking which ALU result cycles carry real data.
// Asynchronous reset; synchronous clear discards every pulse still in flight.
module alu_valid_pipe #(
  parameter int RES_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [RES_LAT-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < RES_LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[RES_LAT-1];

endmodule

// File: rtl/alu_issue_queue.sv
// Operand-issue stage for the registered ALU: circular FIFO of (opcode, a, b) triples,
// a registered issue stage gated by issue_en, and result_valid aligned to the ALU latency.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DATAW   = ALU_DATAW,
  parameter int OPS     = ALU_OPS,
  parameter int OPCODEW = $clog2(OPS),
  parameter int DEPTH   = 8,
  parameter int RES_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODEW-1:0]       in_opcode,
  input  logic [DATAW-1:0]         in_dataa,
  input  logic [DATAW-1:0]         in_datab,
  input  logic                     issue_en,
  output logic [OPCODEW-1:0]       opcode,
  output logic [DATAW-1:0]         dataa,
  output logic [DATAW-1:0]         datab,
  output logic                     issue_valid,
  output logic                     result_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [OPCODEW-1:0] mem_op [DEPTH];
  logic [DATAW-1:0]   mem_a  [DEPTH];
  logic [DATAW-1:0]   mem_b  [DEPTH];
  logic [PTRW-1:0]    wr_ptr;
  logic [PTRW-1:0]    rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full && !rst;
  // flush wins over both handshakes; an offer during flush is dropped.
  assign push     = in_valid && in_ready && !flush;
  assign pop      = issue_en && !empty && !flush;

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never issued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= in_opcode;
      mem_a[wr_ptr]  <= in_dataa;
      mem_b[wr_ptr]  <= in_datab;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Idle cycles present zeros so the ALU computes a harmless add of zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode      <= '0;
      dataa       <= '0;
      datab       <= '0;
      issue_valid <= 1'b0;
    end else if (pop) begin
      opcode      <= mem_op[rd_ptr];
      dataa       <= mem_a[rd_ptr];
      datab       <= mem_b[rd_ptr];
      issue_valid <= 1'b1;
    end else begin
      opcode      <= '0;
      dataa       <= '0;
      datab       <= '0;
      issue_valid <= 1'b0;
    end
  end

  alu_valid_pipe #(
    .RES_LAT (RES_LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .d     (issue_valid),
    .q     (result_valid)
  );

endmodule
